// File: rtl/vga_framebuffer_dbuf.sv
// Double-buffered pixel store for the VGA path. The draw side and the clear
// engine fill the back bank, scan-out reads the front bank, and banks swap only on vsync.
module vga_framebuffer_dbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int H_PIXELS   = 256,
  parameter int V_PIXELS   = 256,
  parameter int DEPTH      = H_PIXELS * V_PIXELS,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  input  logic                  swap_req,
  input  logic                  vsync,
  output logic                  front_sel,
  output logic                  swap_pending
);

  localparam int MEM_WORDS = 2 ** (ADDR_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  clr_state_t            state_r;
  logic [ADDR_WIDTH:0]   clr_cnt_r;
  logic [DATA_WIDTH-1:0] clr_val_r;
  logic                  clr_bank_r;
  logic                  clear_busy_r;
  logic                  front_sel_r;
  logic                  swap_pending_r;
  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Bank index is the MSB of the internal address: {bank, pixel}.
  logic [DATA_WIDTH-1:0] mem_r [0:MEM_WORDS-1];

  logic                  wr_fire_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  swap_commit_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH:0]   mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  assign wr_ready      = (state_r == ST_IDLE);
  assign wr_fire_s     = wr_valid && wr_ready;
  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);
  assign swap_commit_s = vsync && (swap_pending_r || swap_req) && (state_r == ST_IDLE);

  // Single memory write port shared by the clear engine and the draw side.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {(ADDR_WIDTH + 1){1'b0}};
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = {clr_bank_r, clr_cnt_r[ADDR_WIDTH-1:0]};
        mem_wdata_s = clr_val_r;
      end
      ST_IDLE: begin
        mem_we_s    = wr_fire_s && wr_in_range_s;
        mem_waddr_s = {~front_sel_r, wr_addr};
        mem_wdata_s = wr_data;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {(ADDR_WIDTH + 1){1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Pixel storage, deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Clear engine: walks the latched bank from 0 to DEPTH-1, one word per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      clr_cnt_r    <= {(ADDR_WIDTH + 1){1'b0}};
      clr_val_r    <= {DATA_WIDTH{1'b0}};
      clr_bank_r   <= 1'b0;
      clear_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clear_start) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= {(ADDR_WIDTH + 1){1'b0}};
            clr_val_r    <= clear_value;
            clr_bank_r   <= ~front_sel_r;
            clear_busy_r <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_r == LAST_W) begin
            state_r      <= ST_IDLE;
            clear_busy_r <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + ONE_W;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          clear_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Swap control: a request waits in swap_pending until a vsync with the clear engine idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front_sel_r    <= 1'b0;
      swap_pending_r <= 1'b0;
    end else if (swap_commit_s) begin
      front_sel_r    <= ~front_sel_r;
      swap_pending_r <= 1'b0;
    end else if (swap_req) begin
      swap_pending_r <= 1'b1;
    end
  end

  // Scan-out read: one-cycle latency, out-of-range addresses return zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= rd_in_range_s ? mem_r[{front_sel_r, rd_addr}] : {DATA_WIDTH{1'b0}};
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign clear_busy   = clear_busy_r;
  assign front_sel    = front_sel_r;
  assign swap_pending = swap_pending_r;

endmodule

// File: tb/tb_vga_framebuffer_dbuf.sv
// Scoreboard bench for vga_framebuffer_dbuf on a small 6x5 frame
// (DEPTH=30, so address DEPTH is still representable on the 5-bit ports).
module tb_vga_framebuffer_dbuf;

  localparam int DW    = 8;
  localparam int H     = 6;
  localparam int V     = 5;
  localparam int DEPTH = H * V;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          clear_busy;
  logic          swap_req;
  logic          vsync;
  logic          front_sel;
  logic          swap_pending;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl [0:1][0:DEPTH-1];
  int            mdl_front;
  logic          mdl_pending;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;

  always #5 clock = ~clock;

  vga_framebuffer_dbuf #(
    .DATA_WIDTH(DW),
    .H_PIXELS  (H),
    .V_PIXELS  (V)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .clear_busy  (clear_busy),
    .swap_req    (swap_req),
    .vsync       (vsync),
    .front_sel   (front_sel),
    .swap_pending(swap_pending)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a[AW-1:0];
    wr_data  = d;
    if (a < DEPTH) mdl[1 - mdl_front][a] = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic issue_read(input int a);
    rd_en   = 1'b1;
    rd_addr = a[AW-1:0];
    exp_q.push_back((a < DEPTH) ? mdl[mdl_front][a] : 8'h00);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic swap_then_vsync();
    swap_req    = 1'b1;
    mdl_pending = 1'b1;
    tick();
    swap_req = 1'b0;
    vsync    = 1'b1;
    tick();
    vsync       = 1'b0;
    mdl_front   = 1 - mdl_front;
    mdl_pending = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
    rd_en = 1'b0; rd_addr = 5'd0; clear_start = 1'b0; clear_value = 8'h00;
    swap_req = 1'b0; vsync = 1'b0;
    mdl_front = 0; mdl_pending = 1'b0;
    #3;
    checks++;
    if ({front_sel, swap_pending, clear_busy, rd_valid, rd_data} !== {4'b0000, 8'h00}) begin
      failures++;
      $display("FAIL reset_outputs got fs=%b sp=%b cb=%b rv=%b rd=%h exp all zero",
               front_sel, swap_pending, clear_busy, rd_valid, rd_data);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
    end
  endtask

  task automatic init_banks();
    for (int i = 0; i < DEPTH; i++) do_write(i, 8'h40 + 8'(i));
    swap_then_vsync();
    for (int i = 0; i < DEPTH; i++) do_write(i, 8'h80 + 8'(i));
    swap_then_vsync();
    checks++;
    if (front_sel !== 1'(mdl_front)) begin
      failures++;
      $display("FAIL init_front got=%b exp=%0d", front_sel, mdl_front);
    end
  endtask

  task automatic test_swap_basic();
    do_write(5, 8'hA3);
    issue_read(5);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
      failures++;
      $display("FAIL read_old_front got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, exp_v);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== exp_v) begin
      failures++;
      $display("FAIL read_hold got v=%b d=%h exp v=0 d=%h", rd_valid, rd_data, exp_v);
    end
    swap_then_vsync();
    checks++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL swap_commit got fs=%b sp=%b exp fs=1 sp=0", front_sel, swap_pending);
    end
    issue_read(5);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v || exp_v !== 8'hA3) begin
      failures++;
      $display("FAIL read_new_front got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, exp_v);
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    logic ready_seen = 1'b0;
    clear_start = 1'b1; clear_value = 8'h1F;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 8'hEE;
    tick();
    clear_start = 1'b0; clear_value = 8'h55;
    for (int k = 0; k < DEPTH + 10 && clear_busy; k++) begin
      if (wr_ready !== 1'b0) ready_seen = 1'b1;
      busy_cnt++;
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (busy_cnt !== DEPTH || clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_duration got=%0d busy=%b exp=%0d", busy_cnt, clear_busy, DEPTH);
    end
    checks++;
    if (ready_seen !== 1'b0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_wr_ready got seen_high=%b now=%b exp 0/1", ready_seen, wr_ready);
    end
    for (int i = 0; i < DEPTH; i++) mdl[1 - mdl_front][i] = 8'h1F;
    swap_then_vsync();
    for (int j = 0; j < 3; j++) begin
      int a;
      a = (j == 0) ? 0 : ((j == 1) ? DEPTH / 2 : DEPTH - 1);
      issue_read(a);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v || exp_v !== 8'h1F) begin
        failures++;
        $display("FAIL clear_read addr=%0d got=%h exp=%h", a, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_swap_during_clear();
    int fs_before;
    fs_before = mdl_front;
    clear_start = 1'b1; clear_value = 8'h2C;
    tick();
    clear_start = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    checks++;
    if (front_sel !== 1'(fs_before) || swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL vsync_in_clear got fs=%b sp=%b exp fs=%0d sp=1", front_sel, swap_pending, fs_before);
    end
    for (int k = 0; k < DEPTH + 10 && clear_busy; k++) tick();
    checks++;
    if (clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_timeout got busy=%b exp=0", clear_busy);
    end
    for (int i = 0; i < DEPTH; i++) mdl[1 - mdl_front][i] = 8'h2C;
    vsync = 1'b1; tick(); vsync = 1'b0;
    mdl_front = 1 - mdl_front;
    checks++;
    if (front_sel !== 1'(mdl_front) || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL retry_swap got fs=%b sp=%b exp fs=%0d sp=0", front_sel, swap_pending, mdl_front);
    end
    issue_read(7);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_data !== exp_v || exp_v !== 8'h2C) begin
      failures++;
      $display("FAIL retry_read got=%h exp=%h", rd_data, exp_v);
    end
    vsync = 1'b1; tick(); vsync = 1'b0;
    checks++;
    if (front_sel !== 1'(mdl_front)) begin
      failures++;
      $display("FAIL idle_vsync got fs=%b exp=%0d", front_sel, mdl_front);
    end
  endtask

  task automatic test_same_cycle();
    swap_req = 1'b1; vsync = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 8'h5A;
    mdl[1 - mdl_front][9] = 8'h5A;
    tick();
    swap_req = 1'b0; vsync = 1'b0; wr_valid = 1'b0;
    mdl_front = 1 - mdl_front;
    checks++;
    if (front_sel !== 1'(mdl_front) || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_swap got fs=%b sp=%b exp fs=%0d sp=0", front_sel, swap_pending, mdl_front);
    end
    issue_read(9);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_data !== exp_v || exp_v !== 8'h5A) begin
      failures++;
      $display("FAIL same_cycle_write got=%h exp=%h", rd_data, exp_v);
    end
  endtask

  task automatic test_back_to_back(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en   = 1'b1;
      rd_addr = i[AW-1:0];
      exp_q.push_back(mdl[mdl_front][i]);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_v) begin
        failures++;
        $display("FAIL b2b_%s addr=%0d got v=%b d=%h exp v=1 d=%h", tag, i, rd_valid, rd_data, exp_v);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL oor_wr_ready got=%b exp=1", wr_ready);
    end
    do_write(DEPTH, 8'h77);
    do_write(31, 8'h78);
    test_back_to_back("front");
    swap_then_vsync();
    test_back_to_back("back");
    issue_read(DEPTH);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL oor_read got v=%b d=%h exp v=1 d=00", rd_valid, rd_data);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid_clear();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    checks++;
    if (swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL pending_set got=%b exp=1", swap_pending);
    end
    clear_start = 1'b1; clear_value = 8'h66; tick(); clear_start = 1'b0;
    tick();
    issue_read(2);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_v || clear_busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got v=%b d=%h busy=%b exp v=1 d=%h busy=1", rd_valid, rd_data, clear_busy, exp_v);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({front_sel, swap_pending, clear_busy, rd_valid, rd_data} !== {4'b0000, 8'h00}) begin
      failures++;
      $display("FAIL midclear_reset got fs=%b sp=%b cb=%b rv=%b rd=%h exp all zero",
               front_sel, swap_pending, clear_busy, rd_valid, rd_data);
    end
    mdl_front = 0; mdl_pending = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got=%b exp=1", wr_ready);
    end
    do_write(4, 8'hC3);
    swap_then_vsync();
    issue_read(4);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_data !== exp_v || exp_v !== 8'hC3 || front_sel !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_write got d=%h fs=%b exp d=%h fs=1", rd_data, front_sel, exp_v);
    end
  endtask

  initial begin
    test_reset();
    init_banks();
    test_swap_basic();
    test_clear();
    test_swap_during_clear();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
